// File: rtl/pdp8_pkg.sv
// rtl/pdp8_pkg.sv - shared codes for the PDP-8 IOT bus controller
package pdp8_pkg;

    // CPU major states
    localparam logic [3:0] F0 = 4'd0;
    localparam logic [3:0] F1 = 4'd1;
    localparam logic [3:0] F2 = 4'd2;
    localparam logic [3:0] F3 = 4'd3;

    // Interrupt-enable system states
    typedef enum logic [1:0] {
        IE_OFF  = 2'd0,
        IE_PEND = 2'd1,
        IE_ON   = 2'd2
    } ie_state_t;

    // Own IOT function codes (mb[2:0]) and device code
    localparam logic [2:0] IOT_SKON = 3'o0;
    localparam logic [2:0] IOT_ION  = 3'o1;
    localparam logic [2:0] IOT_IOF  = 3'o2;
    localparam logic [5:0] DEV_CPU  = 6'o00;

endpackage

// File: rtl/pdp8_prio_enc.sv
// rtl/pdp8_prio_enc.sv - lowest-index priority encoder (slot 0 wins)
module pdp8_prio_enc #(
    parameter int NDEV = 8,
    parameter int IDXW = 3
) (
    input  logic [NDEV-1:0] i_req,
    output logic [NDEV-1:0] o_onehot,
    output logic [IDXW-1:0] o_idx,
    output logic            o_any
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        o_idx = '0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = IDXW'(i);
            end
        end
        o_onehot = i_req & (~i_req + NDEV'(1));
        o_any    = |i_req;
    end

endmodule

// File: rtl/pdp8_io_ctl.sv
// rtl/pdp8_io_ctl.sv - IOT bus merge, interrupt-enable system and interrupt request
module pdp8_io_ctl
    import pdp8_pkg::*;
#(
    parameter int NDEV = 8,
    parameter int IDXW = 3
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_iot,
    input  logic [3:0]         i_state,
    input  logic [11:0]        i_mb,
    input  logic [5:0]         i_io_select,
    input  logic               i_int_ack,
    input  logic [NDEV-1:0]    i_dev_selected,
    input  logic [NDEV-1:0]    i_dev_skip,
    input  logic [NDEV-1:0]    i_dev_interrupt,
    input  logic [NDEV*12-1:0] i_dev_data,
    output logic               o_io_selected,
    output logic               o_io_skip,
    output logic [11:0]        o_io_data_in,
    output logic               o_io_skip_q,
    output logic               o_interrupt_req,
    output logic [IDXW-1:0]    o_int_src,
    output logic               o_int_en,
    output logic               o_bus_err
);

    ie_state_t          r_ie;
    ie_state_t          w_ie_next;
    logic               r_int_req;
    logic [IDXW-1:0]    r_int_src;
    logic               r_src_frozen;
    logic               r_skip_q;
    logic               r_bus_err;

    logic               w_f1_iot;
    logic               w_own_iot;
    logic               w_skon;
    logic               w_ion;
    logic               w_iof;
    logic               w_own_skip;
    logic               w_int_en;
    logic               w_multi_sel;
    logic [11:0]        w_data;

    logic [NDEV-1:0]    w_sel_onehot;
    logic [IDXW-1:0]    w_int_idx;
    logic               w_int_any;
    logic [NDEV-1:0]    w_unused_int_onehot;
    logic [IDXW-1:0]    w_unused_sel_idx;
    logic               w_unused_sel_any;
    logic [8:0]         w_unused_mb;

    // mb[8:3] arrives separately as io_select; the upper opcode bits are implied by iot
    assign w_unused_mb = i_mb[11:3];

    pdp8_prio_enc #(.NDEV(NDEV), .IDXW(IDXW)) u_int_enc (
        .i_req    (i_dev_interrupt),
        .o_onehot (w_unused_int_onehot),
        .o_idx    (w_int_idx),
        .o_any    (w_int_any)
    );

    pdp8_prio_enc #(.NDEV(NDEV), .IDXW(IDXW)) u_sel_enc (
        .i_req    (i_dev_selected),
        .o_onehot (w_sel_onehot),
        .o_idx    (w_unused_sel_idx),
        .o_any    (w_unused_sel_any)
    );

    assign w_f1_iot    = (i_state == F1) && i_iot;
    assign w_own_iot   = w_f1_iot && (i_io_select == DEV_CPU);
    assign w_skon      = w_own_iot && (i_mb[2:0] == IOT_SKON);
    assign w_ion       = w_own_iot && (i_mb[2:0] == IOT_ION);
    assign w_iof       = w_own_iot && (i_mb[2:0] == IOT_IOF);
    assign w_int_en    = (r_ie == IE_ON);
    assign w_own_skip  = w_skon && w_int_en;
    assign w_multi_sel = (i_dev_selected & (i_dev_selected - NDEV'(1))) != '0;

    // Data mux: the lowest selected slot drives the bus even under contention
    always_comb begin
        w_data = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (w_sel_onehot[i]) begin
                w_data = i_dev_data[12*i +: 12];
            end
        end
    end

    // CPU-facing bus outputs, only meaningful during the IOT's F1 cycle
    always_comb begin
        o_io_selected = w_f1_iot && ((|i_dev_selected) || (i_io_select == DEV_CPU));
        o_io_skip     = w_f1_iot && ((|(i_dev_skip & i_dev_selected)) || w_own_skip);
        o_io_data_in  = w_f1_iot ? w_data : 12'o0000;
    end

    // IE next state: ack/IOF/SKON always disable; ION arms; the next F0 enables
    always_comb begin
        w_ie_next = r_ie;
        if (i_int_ack || w_iof || w_skon) begin
            w_ie_next = IE_OFF;
        end else begin
            case (r_ie)
                IE_OFF:  if (w_ion) w_ie_next = IE_PEND;
                IE_PEND: if (i_state == F0) w_ie_next = IE_ON;
                IE_ON:   w_ie_next = IE_ON;
                default: w_ie_next = IE_OFF;
            endcase
        end
    end

    // IE state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ie <= IE_OFF;
        end else begin
            r_ie <= w_ie_next;
        end
    end

    // Interrupt request/source, registered skip and sticky contention flag
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_int_req    <= 1'b0;
            r_int_src    <= '0;
            r_src_frozen <= 1'b0;
            r_skip_q     <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            // Requiring the next IE state too keeps a same-cycle IOF/SKON from leaking a request
            r_int_req <= w_int_en && (w_ie_next == IE_ON) && w_int_any;
            if (i_int_ack) begin
                r_src_frozen <= 1'b1;
            end else if (w_int_en) begin
                r_src_frozen <= 1'b0;
            end
            if (!i_int_ack && (!r_src_frozen || w_int_en)) begin
                r_int_src <= w_int_idx;
            end
            if (i_state == F1) begin
                r_skip_q <= o_io_skip;
            end
            if (w_f1_iot && w_multi_sel) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign o_io_skip_q     = r_skip_q;
    assign o_interrupt_req = r_int_req;
    assign o_int_src       = r_int_src;
    assign o_int_en        = w_int_en;
    assign o_bus_err       = r_bus_err;

endmodule

// File: tb/tb_pdp8_io_ctl.sv
// tb/tb_pdp8_io_ctl.sv - directed self-checking bench for pdp8_io_ctl
module tb_pdp8_io_ctl;

    localparam int NDEV = 8;
    localparam int IDXW = 3;

    localparam logic [3:0] S_F0 = 4'd0;
    localparam logic [3:0] S_F1 = 4'd1;
    localparam logic [3:0] S_F2 = 4'd2;
    localparam logic [3:0] S_F3 = 4'd3;

    logic               clk = 1'b0;
    logic               reset;
    logic               iot;
    logic [3:0]         state;
    logic [11:0]        mb;
    logic [5:0]         io_select;
    logic               int_ack;
    logic [NDEV-1:0]    dev_selected;
    logic [NDEV-1:0]    dev_skip;
    logic [NDEV-1:0]    dev_interrupt;
    logic [NDEV*12-1:0] dev_data;
    logic               io_selected;
    logic               io_skip;
    logic [11:0]        io_data_in;
    logic               io_skip_q;
    logic               interrupt_req;
    logic [IDXW-1:0]    int_src;
    logic               int_en;
    logic               bus_err;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pdp8_io_ctl #(.NDEV(NDEV), .IDXW(IDXW)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_iot           (iot),
        .i_state         (state),
        .i_mb            (mb),
        .i_io_select     (io_select),
        .i_int_ack       (int_ack),
        .i_dev_selected  (dev_selected),
        .i_dev_skip      (dev_skip),
        .i_dev_interrupt (dev_interrupt),
        .i_dev_data      (dev_data),
        .o_io_selected   (io_selected),
        .o_io_skip       (io_skip),
        .o_io_data_in    (io_data_in),
        .o_io_skip_q     (io_skip_q),
        .o_interrupt_req (interrupt_req),
        .o_int_src       (int_src),
        .o_int_en        (int_en),
        .o_bus_err       (bus_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cpu_iot(input logic [11:0] word);
        state     = S_F1;
        iot       = 1'b1;
        mb        = word;
        io_select = word[8:3];
    endtask

    task automatic cpu_idle(input logic [3:0] st);
        state = st;
        iot   = 1'b0;
        mb    = 12'o7000;
        io_select = 6'o70;
    endtask

    initial begin
        reset = 1'b1; int_ack = 1'b0;
        dev_selected = '0; dev_skip = '0; dev_interrupt = '0; dev_data = '0;
        cpu_idle(S_F2);
        step(); step();
        reset = 1'b0;

        // Reset state
        expect_val("rst_int_en", 32'd0);
        expect_val("rst_req", 32'd0);
        expect_val("rst_src", 32'd0);
        expect_val("rst_skip_q", 32'd0);
        expect_val("rst_bus_err", 32'd0);
        check(32'(int_en)); check(32'(interrupt_req)); check(32'(int_src));
        check(32'(io_skip_q)); check(32'(bus_err));

        // 1: ION delay
        cpu_iot(12'o6001);
        settle();
        expect_val("ion_selected", 32'd1);
        expect_val("ion_skip", 32'd0);
        check(32'(io_selected)); check(32'(io_skip));
        step();
        expect_val("ion_pend_int_en", 32'd0);
        check(32'(int_en));
        dev_interrupt = 8'b0000_0100;
        cpu_idle(S_F2); step();
        expect_val("ion_f2_req", 32'd0); check(32'(interrupt_req));
        cpu_idle(S_F3); step();
        expect_val("ion_f3_req", 32'd0); check(32'(interrupt_req));
        cpu_idle(S_F0); step();
        expect_val("ion_f0_req", 32'd0);
        expect_val("ion_f0_int_en", 32'd1);
        check(32'(interrupt_req)); check(32'(int_en));
        cpu_idle(S_F1); step();
        expect_val("ion_req_up", 32'd1);
        expect_val("ion_src", 32'd2);
        check(32'(interrupt_req)); check(32'(int_src));

        // 2: priority change and ack freeze
        cpu_idle(S_F2);
        dev_interrupt = 8'b1010_0000; step();
        expect_val("prio_src5", 32'd5); expect_val("prio_req", 32'd1);
        check(32'(int_src)); check(32'(interrupt_req));
        dev_interrupt = 8'b1010_0010; step();
        expect_val("prio_src1", 32'd1); check(32'(int_src));
        int_ack = 1'b1; step(); int_ack = 1'b0;
        expect_val("ack_req", 32'd0); expect_val("ack_int_en", 32'd0);
        expect_val("ack_src", 32'd1);
        check(32'(interrupt_req)); check(32'(int_en)); check(32'(int_src));
        dev_interrupt = 8'b1000_0000; step();
        expect_val("ack_src_frozen", 32'd1); expect_val("ack_req_off", 32'd0);
        check(32'(int_src)); check(32'(interrupt_req));

        // 3: SKON
        dev_interrupt = '0;
        cpu_iot(12'o6001); step();
        cpu_idle(S_F0); step();
        expect_val("skon_pre_int_en", 32'd1); check(32'(int_en));
        cpu_iot(12'o6000); settle();
        expect_val("skon_skip", 32'd1); check(32'(io_skip));
        step();
        expect_val("skon_skip_q", 32'd1); expect_val("skon_int_en", 32'd0);
        check(32'(io_skip_q)); check(32'(int_en));
        cpu_idle(S_F2); step();
        expect_val("skon_skip_q_hold", 32'd1); check(32'(io_skip_q));
        cpu_iot(12'o6000); settle();
        expect_val("skon2_skip", 32'd0); check(32'(io_skip));
        step();
        expect_val("skon2_skip_q", 32'd0); check(32'(io_skip_q));

        // 4: data mux and contention
        dev_data = '0;
        dev_data[12*0 +: 12] = 12'o0101;
        dev_data[12*1 +: 12] = 12'o1234;
        dev_data[12*2 +: 12] = 12'o7777;
        dev_selected = 8'b0000_0110;
        dev_skip     = 8'b0000_0100;
        cpu_idle(S_F2); settle();
        expect_val("mux_gated", 32'd0); check(32'(io_data_in));
        cpu_iot(12'o6030); settle();
        expect_val("mux_data", 32'o1234); expect_val("mux_sel", 32'd1);
        expect_val("mux_skip", 32'd1);
        check(32'(io_data_in)); check(32'(io_selected)); check(32'(io_skip));
        step();
        expect_val("bus_err_set", 32'd1); check(32'(bus_err));
        dev_selected = '0; dev_skip = '0;
        cpu_idle(S_F3); step(); step(); step();
        expect_val("bus_err_sticky", 32'd1); check(32'(bus_err));

        // 5a: ack and ION together
        dev_interrupt = 8'b0000_0001;
        cpu_iot(12'o6001); int_ack = 1'b1; step(); int_ack = 1'b0;
        expect_val("ackion_int_en", 32'd0); check(32'(int_en));
        cpu_idle(S_F0); step();
        expect_val("ackion_f0_int_en", 32'd0); expect_val("ackion_req", 32'd0);
        check(32'(int_en)); check(32'(interrupt_req));

        // 5b: IOF with a rising device interrupt
        dev_interrupt = '0;
        cpu_iot(12'o6001); step();
        cpu_idle(S_F0); step();
        expect_val("iof_pre_int_en", 32'd1); check(32'(int_en));
        cpu_iot(12'o6002); dev_interrupt = 8'b0000_1000; step();
        expect_val("iof_req", 32'd0); expect_val("iof_int_en", 32'd0);
        check(32'(interrupt_req)); check(32'(int_en));
        cpu_idle(S_F2); step();
        expect_val("iof_req_later", 32'd0); check(32'(interrupt_req));

        // 6: reset in IE_PEND mid-F2
        dev_interrupt = '0;
        dev_selected = 8'b0000_0001; dev_skip = 8'b0000_0001;
        cpu_iot(12'o6001); step();
        dev_selected = '0; dev_skip = '0;
        expect_val("pre_rst_skip_q", 32'd1); check(32'(io_skip_q));
        cpu_idle(S_F2); reset = 1'b1; step(); reset = 1'b0;
        expect_val("mid_rst_int_en", 32'd0); expect_val("mid_rst_req", 32'd0);
        expect_val("mid_rst_skip_q", 32'd0); expect_val("mid_rst_bus_err", 32'd0);
        check(32'(int_en)); check(32'(interrupt_req));
        check(32'(io_skip_q)); check(32'(bus_err));
        dev_interrupt = 8'b0000_0010;
        cpu_idle(S_F0); step();
        cpu_idle(S_F1); step();
        cpu_idle(S_F0); step();
        cpu_idle(S_F1); step();
        expect_val("post_rst_int_en", 32'd0); expect_val("post_rst_req", 32'd0);
        check(32'(int_en)); check(32'(interrupt_req));

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
